// File: rtl/pipe_ctrl_if.sv
// Fetch/decode handshake bundle between the pipeline controller and its
// neighbours: hazard/branch requests in, fetch address and IF/ID controls out.
interface pipe_ctrl_if;
    logic        imem_ready;
    logic        load_use;
    logic        branch_req;
    logic [13:0] branch_target;
    logic        halt_req;
    logic [13:0] pc_out;
    logic [13:0] return_addr;
    logic        if_id_en;
    logic        if_id_flush;
    logic        take_branch;
    logic [1:0]  state_out;

    modport slave (
        input  imem_ready, load_use, branch_req, branch_target, halt_req,
        output pc_out, return_addr, if_id_en, if_id_flush, take_branch, state_out
    );

    modport master (
        output imem_ready, load_use, branch_req, branch_target, halt_req,
        input  pc_out, return_addr, if_id_en, if_id_flush, take_branch, state_out
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Fetch-stage pipeline controller: PC sequencing, stall/flush/halt FSM.
// Optional saturating performance counters enabled by PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter logic [13:0] RESET_VECTOR = 14'h0000
) (
    input  logic         clock,
    input  logic         nreset,
    pipe_ctrl_if.slave   bus,
    output logic [15:0]  stall_cnt,
    output logic [15:0]  flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [13:0] pc_q, pc_d;
    logic        if_id_en_s;
    logic        if_id_flush_s;
    logic        take_branch_s;

    // State and PC registers; the synchronous reset is folded into the next-state logic.
    always_ff @(posedge clock) begin
        state_q <= state_d;
        pc_q    <= pc_d;
    end

    // Next-state, next-PC and IF/ID control decode.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_en_s    = 1'b0;
        if_id_flush_s = 1'b0;
        take_branch_s = 1'b0;
        if (!nreset) begin
            // The reset cycle pushes a bubble into IF/ID.
            if_id_flush_s = 1'b1;
            pc_d          = RESET_VECTOR;
            state_d       = RUN;
        end else begin
            case (state_q)
                RUN, STALL: begin
                    if (bus.branch_req) begin
                        take_branch_s = 1'b1;
                        if_id_flush_s = 1'b1;
                        pc_d          = bus.branch_target;
                        state_d       = FLUSH;
                    end else if (bus.halt_req) begin
                        state_d = HALT;
                    end else if (bus.load_use || !bus.imem_ready) begin
                        state_d = STALL;
                    end else begin
                        if_id_en_s = 1'b1;
                        pc_d       = pc_q + 14'd1;
                        state_d    = RUN;
                    end
                end
                FLUSH: begin
                    if_id_flush_s = 1'b1;
                    pc_d          = pc_q + 14'd1;
                    state_d       = RUN;
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    assign bus.pc_out      = pc_q;
    assign bus.return_addr = pc_q + 14'd1;
    assign bus.state_out   = state_q;
    assign bus.if_id_en    = if_id_en_s;
    assign bus.if_id_flush = if_id_flush_s;
    assign bus.take_branch = take_branch_s;

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Performance counter registers.
    always_ff @(posedge clock) begin
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    // Saturating increments; reset-cycle flushes are not counted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!nreset) begin
            stall_cnt_d = 16'h0000;
            flush_cnt_d = 16'h0000;
        end else begin
            if ((state_q == STALL) && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
            if (if_id_flush_s && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_d = flush_cnt_q + 16'd1;
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 16'h0000;
    assign flush_cnt = 16'h0000;
`endif

endmodule
